data_memory_ctrl: RTL and testbench

Parametrised byte-addressable data memory with a request/ready handshake. It is the successor to the single-cycle word memory in the datapath's MEM stage. It adds byte, halfword and word accesses with per-lane writes, sign or zero extension on reads, and a configurable number of wait states. It also detects misaligned and illegal requests. It sits between the MEM-stage control and the load/store path. The stage stalls while `Busy` is high.

---
 rtl/data_memory_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressable data memory with wait states and request checking
//
// Purpose: word-organised data memory serving byte, half and word loads/stores
// with per-lane writes, sign/zero extension and WAIT_STATES extra cycles of latency.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   MemRead/MemWrite  request strobes, sampled only while idle
//   Address, Size     byte address and access size (00 byte, 01 half, 10 word)
//   Unsigned          zero-extend (1) or sign-extend (0) sub-word loads
//   WriteData         right-justified store data
//   ReadData          extended load result, held until the next load completes
//   Ready             one-cycle completion pulse
//   Busy              high while a request is in flight
//   Error             one-cycle pulse for a rejected request
module data_memory_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Ready,
    output logic              Busy,
    output logic              Error
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q;

    // Captured request, valid from acceptance until the commit edge
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem_q [DEPTH];

    logic              legal;
    logic              accept;
    logic              commit;

    // Operands used at the commit edge
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [1:0]        c_size;
    logic              c_uns;
    logic [31:0]       c_wdata;

    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_ext;

    always_comb begin
        legal = (MemRead ^ MemWrite);
        if (Size == 2'b11)
            legal = 1'b0;
        if (Size == 2'b01 && Address[0])
            legal = 1'b0;
        if (Size == 2'b10 && Address[1:0] != 2'b00)
            legal = 1'b0;
    end

    assign accept = (state_q == ST_IDLE) && legal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end else if (MemRead || MemWrite) begin
                    err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // live inputs are used instead of the (not yet loaded) capture registers.
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_write = MemWrite;
            c_addr  = Address;
            c_size  = Size;
            c_uns   = Unsigned;
            c_wdata = WriteData;
        end else begin
            c_write = write_q;
            c_addr  = addr_q;
            c_size  = size_q;
            c_uns   = uns_q;
            c_wdata = wdata_q;
        end
    end

    // Replicating the store data across lanes lets the lane enables alone
    // pick the destination bytes.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = c_wdata;
        case (c_size)
            2'b00: begin
                lane_en   = 4'b0001 << c_addr[1:0];
                lane_data = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = c_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{c_wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = c_wdata;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem_q[c_addr[ADDR_W-1:2]];
        rd_shift = rd_word >> {c_addr[1:0], 3'b000};
        case (c_size)
            2'b00:   rd_ext = {{24{~c_uns & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = {{16{~c_uns & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (commit && !c_write)
                rdata_q <= rd_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= MemWrite;
            addr_q  <= Address;
            size_q  <= Size;
            uns_q   <= Unsigned;
            wdata_q <= WriteData;
        end
    end

    // Array contents survive reset; reset only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && commit && c_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem_q[c_addr[ADDR_W-1:2]][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = (state_q == ST_RESP);
    assign Busy     = (state_q != ST_IDLE);
    assign Error    = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  mr, mw, un;
    logic [7:0]  ad [3];
    logic [1:0]  sz [3];
    logic [31:0] wd [3];
    logic [31:0] rd [3];
    logic [2:0]  rdy, bsy, er;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [3][256];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_ctrl #(
            .ADDR_W     (8),
            .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 3 : 0))
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .MemRead  (mr[g]),
            .MemWrite (mw[g]),
            .Address  (ad[g]),
            .Size     (sz[g]),
            .Unsigned (un[g]),
            .WriteData(wd[g]),
            .ReadData (rd[g]),
            .Ready    (rdy[g]),
            .Busy     (bsy[g]),
            .Error    (er[g])
        );
    end

    function automatic int ws_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 3 : 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected load result computed straight from the byte-level model
    function automatic logic [31:0] model_read(input int s, input logic [7:0] a,
                                               input logic [1:0] z, input logic u);
        logic [31:0] v;
        int nb;
        nb = (z == 2'b00) ? 1 : ((z == 2'b01) ? 2 : 4);
        v = 32'd0;
        for (int i = 0; i < nb; i++)
            v = v | (32'(ref_mem[s][int'(a) + i]) << (8 * i));
        if (nb < 4 && !u && v[8*nb-1])
            v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic access(input int s, input logic r, input logic w, input logic [7:0] a,
                          input logic [1:0] z, input logic u, input logic [31:0] d);
        logic legal;
        logic [31:0] exp;
        int n;
        int nb;
        legal = (r != w) && (z != 2'b11) && !(z == 2'b01 && a[0]) &&
                !(z == 2'b10 && a[1:0] != 2'b00);
        nb = (z == 2'b00) ? 1 : ((z == 2'b01) ? 2 : 4);
        exp = model_read(s, a, z, u);
        @(negedge clk);
        mr[s] = r; mw[s] = w; ad[s] = a; sz[s] = z; un[s] = u; wd[s] = d;
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs once the request has been sampled
        mr[s] = 1'b0; mw[s] = 1'b0;
        ad[s] = 8'($urandom); wd[s] = $urandom; sz[s] = 2'($urandom); un[s] = 1'($urandom);
        if (!legal) begin
            check("err_pulse", 32'(er[s]), 32'(r | w));
            check("err_busy", 32'(bsy[s]), 0);
            check("err_ready", 32'(rdy[s]), 0);
            check("err_rdata_hold", rd[s], last_rd[s]);
            @(negedge clk);
            check("err_clear", 32'(er[s]), 0);
        end else begin
            check("busy_accept", 32'(bsy[s]), 1);
            n = 1;
            while (!rdy[s] && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("latency", n, ws_of(s) + 1);
            check("busy_at_ready", 32'(bsy[s]), 1);
            check("err_at_ready", 32'(er[s]), 0);
            if (w) begin
                for (int i = 0; i < nb; i++)
                    ref_mem[s][int'(a) + i] = d[8*i +: 8];
            end else begin
                check("rdata", rd[s], exp);
                last_rd[s] = exp;
            end
            @(negedge clk);
            check("ready_drop", 32'(rdy[s]), 0);
            check("busy_drop", 32'(bsy[s]), 0);
        end
    endtask

    initial begin
        int seen;
        int op;
        logic [31:0] exp;
        rst = 3'b111; mr = 3'b000; mw = 3'b000; un = 3'b000;
        for (int s = 0; s < 3; s++) begin
            ad[s] = 8'd0; sz[s] = 2'd0; wd[s] = 32'd0; last_rd[s] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 3'b000;
        for (int s = 0; s < 3; s++) begin
            check("rst_rdata", rd[s], 0);
            check("rst_ready", 32'(rdy[s]), 0);
            check("rst_busy", 32'(bsy[s]), 0);
            check("rst_error", 32'(er[s]), 0);
        end

        // Define the first 64 bytes of every array
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 16; k++)
                access(s, 1'b0, 1'b1, 8'(4 * k), 2'b10, 1'b0, $urandom);

        // Directed cases on the two-wait-state instance
        access(0, 1'b0, 1'b1, 8'h08, 2'b10, 1'b0, 32'h1234_5678);
        access(0, 1'b1, 1'b0, 8'h08, 2'b10, 1'b0, 32'h0);
        check("word_rd", rd[0], 32'h1234_5678);
        access(0, 1'b0, 1'b1, 8'h10, 2'b10, 1'b0, 32'h1122_3344);
        access(0, 1'b0, 1'b1, 8'h11, 2'b00, 1'b0, 32'h0000_00AB);
        access(0, 1'b1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0);
        check("byte_lane", rd[0], 32'h1122_AB44);
        access(0, 1'b0, 1'b1, 8'h12, 2'b01, 1'b0, 32'h0000_CDEF);
        access(0, 1'b1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0);
        check("half_lane", rd[0], 32'hCDEF_AB44);
        access(0, 1'b1, 1'b0, 8'h11, 2'b00, 1'b0, 32'h0);
        check("ext_byte_s", rd[0], 32'hFFFF_FFAB);
        access(0, 1'b1, 1'b0, 8'h11, 2'b00, 1'b1, 32'h0);
        check("ext_byte_u", rd[0], 32'h0000_00AB);
        access(0, 1'b1, 1'b0, 8'h12, 2'b01, 1'b0, 32'h0);
        check("ext_half_s", rd[0], 32'hFFFF_CDEF);
        access(0, 1'b1, 1'b0, 8'h10, 2'b00, 1'b0, 32'h0);
        check("ext_byte_pos", rd[0], 32'h0000_0044);
        access(0, 1'b1, 1'b0, 8'h0A, 2'b10, 1'b0, 32'h0);
        access(0, 1'b1, 1'b0, 8'h08, 2'b11, 1'b0, 32'h0);
        access(0, 1'b1, 1'b1, 8'h08, 2'b10, 1'b0, 32'h0);
        access(0, 1'b0, 1'b1, 8'h0B, 2'b01, 1'b0, 32'h0000_9999);
        access(0, 1'b1, 1'b0, 8'h08, 2'b10, 1'b0, 32'h0);
        check("err_no_write", rd[0], 32'h1234_5678);

        // Reset one cycle after accepting a write on the three-wait-state instance
        @(negedge clk);
        mw[1] = 1'b1; ad[1] = 8'h20; sz[1] = 2'b10; wd[1] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        mw[1] = 1'b0; rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        check("rstw_busy", 32'(bsy[1]), 0);
        check("rstw_ready", 32'(rdy[1]), 0);
        check("rstw_error", 32'(er[1]), 0);
        check("rstw_rdata", rd[1], 0);
        last_rd[1] = 32'd0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(rdy[1]) + int'(bsy[1]);
        end
        check("rstw_quiet", seen, 0);
        exp = model_read(1, 8'h20, 2'b10, 1'b0);
        access(1, 1'b1, 1'b0, 8'h20, 2'b10, 1'b0, 32'h0);
        check("rstw_old", rd[1], exp);

        // Zero-wait instance: a held read strobe completes every second cycle
        exp = model_read(2, 8'h08, 2'b10, 1'b0);
        @(negedge clk);
        mr[2] = 1'b1; ad[2] = 8'h08; sz[2] = 2'b10; un[2] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("b2b_ready", 32'(rdy[2]), 32'(k % 2));
            if (k % 2 == 1)
                check("b2b_rdata", rd[2], exp);
        end
        mr[2] = 1'b0;
        last_rd[2] = exp;
        @(negedge clk);
        check("b2b_idle", 32'(bsy[2]), 0);

        // Randomized mix of legal and illegal requests on every instance
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 80; k++) begin
                op = int'($urandom_range(0, 6));
                access(s, 1'(op <= 2 || op == 6), 1'(op >= 3), 8'($urandom_range(0, 60)),
                       2'($urandom), 1'($urandom), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
